piso_serial_scheduler: RTL and testbench
========================================

// Module: piso_serial_scheduler
// PURPOSE
//  Round-robin scheduler that shares one Parallel_In_Serial_Out_Shift_Reg between
//  NUM_REQ parallel-word requesters. Grants one requester, loads its word into the
//  serializer (din/din_en), counts out DATA_WIDTH serial bits (LSB first), and tags
//  the serial stream with frame markers and requester id. Sits between the word
//  producers and the serial link; the shift register itself is instantiated outside.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  DATA_WIDTH  16  word width; must equal the serializer's DATA_WIDTH (>=2)
//  GAP_CYCLES  1   idle cycles inserted after each word's last bit (>=0)
// PORTS
//  clk          in   1                   clock, rising edge
//  resetn       in   1                   asynchronous reset, active low
//  req_valid    in   NUM_REQ             requester i has a word pending
//  req_data     in   NUM_REQ*DATA_WIDTH  word of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready    out  NUM_REQ             one-hot; word i accepted when valid&ready
//  ser_din      out  DATA_WIDTH          to serializer din
//  ser_din_en   out  1                   to serializer din_en (load strobe)
//  ser_dout     in   1                   from serializer dout
//  sout_bit     out  1                   ser_dout forwarded combinationally
//  sout_valid   out  1                   sout_bit is a payload bit
//  sout_first   out  1                   bit 0 of word (with sout_valid)
//  sout_last    out  1                   bit DATA_WIDTH-1 of word (with sout_valid)
//  sout_id      out  $clog2(NUM_REQ)     requester that owns current word
//  busy         out  1                   state != IDLE
// BEHAVIOUR
//  States: IDLE, SHIFT, GAP. Reset (async, resetn=0): state=IDLE, bit_cnt=0,
//   rr_ptr=0, owner=0; all outputs 0 (ser_din=0, ser_din_en=0, req_ready=0,
//   sout_valid/first/last=0, sout_id=0, busy=0) while resetn=0.
//  IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   If any valid: same cycle req_ready[winner]=1, ser_din_en=1,
//   ser_din=req_data[winner]; owner<=winner, rr_ptr<=(winner+1) mod NUM_REQ,
//   bit_cnt<=0, next=SHIFT. Else all of those 0, rr_ptr unchanged.
//  SHIFT: lasts exactly DATA_WIDTH cycles (bit_cnt 0..DATA_WIDTH-1); serializer dout
//   then holds word bit bit_cnt. sout_valid=1, sout_id=owner,
//   sout_first=(bit_cnt==0), sout_last=(bit_cnt==DATA_WIDTH-1). ser_din_en=0,
//   ser_din=0, req_ready=0 throughout (a load would corrupt the shift).
//   On bit_cnt==DATA_WIDTH-1: next=GAP if GAP_CYCLES>0 else IDLE.
//  GAP: GAP_CYCLES cycles, all sout_* and load outputs 0, then IDLE.
//  Latency: load cycle t -> first bit at t+1, last bit at t+DATA_WIDTH.
//   Word period under continuous demand = DATA_WIDTH+1+GAP_CYCLES cycles.
//  Requester rule: req_valid/req_data held stable until accepted; dropping valid
//   before acceptance withdraws the request (no grant, pointer unchanged).
//  Valids arriving during SHIFT/GAP are ignored until IDLE; no starvation:
//   each valid requester granted within NUM_REQ word periods.
//  bit_cnt width $clog2(DATA_WIDTH); never exceeds DATA_WIDTH-1 (no wrap).
//  Reset mid-word: outputs drop to 0 at once; serializer (sync reset) clears on
//   next edge; after release no partial frame resumes, arbitration restarts at 0.
//  sout_bit is forwarded even when sout_valid=0; consumers qualify with sout_valid.
// TESTING (NUM_REQ=4, DATA_WIDTH=16, GAP_CYCLES=1, real serializer attached)
//  Reset: resetn=0 mid-stream -> all outputs 0 same cycle; after release busy=0.
//  Single: req_valid=4'b0010, data1=16'hA5C3 at t -> req_ready=4'b0010 & din_en at t;
//   sout_bit t+1..t+16 = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; first@t+1, last@t+16, id=1.
//  Round-robin: all 4 valid, held -> grants 0,1,2,3,0 at t, t+18, t+36, t+54, t+72.
//  Pointer: grant 2, then only req 0 and 3 valid -> next grant 3, then 0.
//  Blocked: req 0 in SHIFT, req 2 raises valid at bit 5 -> req_ready[2]=0 until
//   IDLE at t+18; din_en never asserted during SHIFT/GAP.
//  GAP_CYCLES=0 build: continuous req 1 -> loads at t, t+17, t+34; no gap bits.

Source files
------------

// File: rtl/piso_serial_scheduler.sv
// Round-robin scheduler sharing one external PISO shift register between NUM_REQ requesters.
// Loads the granted word, then frames its DATA_WIDTH serial bits (LSB first) with first/last/id.
module piso_serial_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [DATA_WIDTH-1:0]           ser_din,
   output logic                            ser_din_en,
   input  logic                            ser_dout,
   output logic                            sout_bit,
   output logic                            sout_valid,
   output logic                            sout_first,
   output logic                            sout_last,
   output logic [$clog2(NUM_REQ)-1:0]      sout_id,
   output logic                            busy
);

   localparam int unsigned IdW     = $clog2(NUM_REQ);
   localparam int unsigned CntW    = $clog2(DATA_WIDTH);
   localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
   logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]        owner_q, owner_d;

   logic                  found;
   logic [IdW-1:0]        winner;
   int unsigned           idx;
   logic [DATA_WIDTH-1:0] grant_data;

   // Rotating priority search starting at rr_ptr.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && req_valid[idx[IdW-1:0]]) begin
            found  = 1'b1;
            winner = idx[IdW-1:0];
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (winner == IdW'(i)) begin
            grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      req_ready  = '0;
      ser_din    = '0;
      ser_din_en = 1'b0;
      sout_valid = 1'b0;
      sout_first = 1'b0;
      sout_last  = 1'b0;
      sout_id    = '0;
      busy       = 1'b0;
      // Outputs are gated by resetn so they drop the moment reset asserts.
      if (resetn) begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  req_ready[winner] = 1'b1;
                  ser_din_en        = 1'b1;
                  ser_din           = grant_data;
                  owner_d           = winner;
                  rr_ptr_d          = (winner == IdW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                  bit_cnt_d         = '0;
                  state_d           = SHIFT;
               end
            end
            SHIFT: begin
               busy       = 1'b1;
               sout_valid = 1'b1;
               sout_id    = owner_q;
               sout_first = (bit_cnt_q == '0);
               sout_last  = (bit_cnt_q == CntW'(DATA_WIDTH - 1));
               if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  gap_cnt_d = '0;
                  state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            GAP: begin
               busy = 1'b1;
               if (gap_cnt_q == GapW'(GapLast)) begin
                  gap_cnt_d = '0;
                  state_d   = IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign sout_bit = ser_dout;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
      end
   end

endmodule

// File: tb/tb_piso_serial_scheduler.sv
// Bench for piso_serial_scheduler with a behavioural serializer; a timeline model
// (cycles since load) predicts every output. A second GAP_CYCLES=0 instance is checked for period.
module tb_piso_serial_scheduler;

   localparam int NR  = 4;
   localparam int DW  = 16;
   localparam int GP  = 1;
   localparam int PER = DW + 1 + GP;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [DW-1:0]     words [NR];
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic [DW-1:0]     ser_din;
   logic              ser_din_en, ser_dout;
   logic              sout_bit, sout_valid, sout_first, sout_last, busy;
   logic [1:0]        sout_id;

   logic [NR-1:0]     g0_ready;
   logic [DW-1:0]     g0_din;
   logic              g0_en, g0_bit, g0_valid, g0_first, g0_last, g0_busy;
   logic [1:0]        g0_id;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NR; g++) begin : g_pack
      assign req_data[g*DW +: DW] = words[g];
   end

   // Serializer: sync reset, load on din_en, otherwise shift right; dout is bit 0.
   logic [DW-1:0] sreg;
   always_ff @(posedge clk) begin
      if (!resetn)         sreg <= '0;
      else if (ser_din_en) sreg <= ser_din;
      else                 sreg <= sreg >> 1;
   end
   assign ser_dout = sreg[0];

   piso_serial_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .GAP_CYCLES(GP)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .ser_din(ser_din), .ser_din_en(ser_din_en), .ser_dout(ser_dout),
      .sout_bit(sout_bit), .sout_valid(sout_valid), .sout_first(sout_first),
      .sout_last(sout_last), .sout_id(sout_id), .busy(busy)
   );

   piso_serial_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .GAP_CYCLES(0)) dut_g0 (
      .clk(clk), .resetn(resetn), .req_valid(4'b0010), .req_data({NR{16'h5A0F}}),
      .req_ready(g0_ready), .ser_din(g0_din), .ser_din_en(g0_en), .ser_dout(1'b0),
      .sout_bit(g0_bit), .sout_valid(g0_valid), .sout_first(g0_first),
      .sout_last(g0_last), .sout_id(g0_id), .busy(g0_busy)
   );

   // Model: phase 0 = free, 1..DW = payload bit phase-1, DW+1..DW+GP = gap.
   int            m_phase = 0;
   int            m_ptr = 0;
   int            m_owner = 0;
   logic [DW-1:0] m_word = '0;
   int            g0_phase = 0;
   int            cyc = 0;
   logic [NR-1:0] accepted = '0;
   int            g_owner[$];
   int            g_cyc[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   // Check outputs for the current inputs, advance the model, then step one clock.
   task automatic cycle();
      logic [NR-1:0] e_ready;
      logic [DW-1:0] e_din;
      logic          e_en, e_v, e_f, e_l, e_busy, e_bit;
      logic [1:0]    e_id, ix;
      int            w;
      #1;
      e_ready = '0; e_din = '0; e_en = 0; e_v = 0; e_f = 0; e_l = 0; e_busy = 0;
      e_id = '0; e_bit = 0; w = -1;
      if (!resetn) begin
         m_phase = 0; m_ptr = 0; g0_phase = 0;
      end else if (m_phase == 0) begin
         for (int k = 0; k < NR; k++) begin
            ix = 2'((m_ptr + k) % NR);
            if (w < 0 && req_valid[ix]) w = int'(ix);
         end
         if (w >= 0) begin
            e_ready[w] = 1'b1; e_en = 1'b1; e_din = words[w];
         end
      end else if (m_phase <= DW) begin
         e_v = 1; e_f = (m_phase == 1); e_l = (m_phase == DW); e_id = 2'(m_owner);
         e_busy = 1; e_bit = m_word[m_phase-1];
      end else begin
         e_busy = 1;
      end
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("ser_din_en", 32'(ser_din_en), 32'(e_en));
      check("ser_din", 32'(ser_din), 32'(e_din));
      check("sout_valid", 32'(sout_valid), 32'(e_v));
      check("sout_first", 32'(sout_first), 32'(e_f));
      check("sout_last", 32'(sout_last), 32'(e_l));
      check("sout_id", 32'(sout_id), 32'(e_id));
      check("busy", 32'(busy), 32'(e_busy));
      if (e_v) check("sout_bit", 32'(sout_bit), 32'(e_bit));
      check("g0_din_en", 32'(g0_en), 32'(resetn && g0_phase == 0));
      check("g0_sout_valid", 32'(g0_valid), 32'(resetn && g0_phase > 0));
      check("g0_sout_last", 32'(g0_last), 32'(resetn && g0_phase == DW));
      accepted = e_ready & req_valid;
      if (resetn) begin
         if (m_phase == 0 && w >= 0) begin
            m_phase = 1; m_owner = w; m_word = words[w]; m_ptr = (w + 1) % NR;
            g_owner.push_back(w); g_cyc.push_back(cyc);
         end else if (m_phase > 0) begin
            m_phase = (m_phase == DW + GP) ? 0 : m_phase + 1;
         end
         g0_phase = (g0_phase == DW) ? 0 : g0_phase + 1;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // Accepted or idle requesters may post a new word; pending ones occasionally withdraw.
   task automatic drive_random();
      for (int i = 0; i < NR; i++) begin
         if (accepted[i] || !req_valid[i]) begin
            if ($urandom_range(0, 2) == 0) begin
               req_valid[i] = 1'b1;
               words[i] = 16'($urandom);
            end else begin
               req_valid[i] = 1'b0;
            end
         end else if ($urandom_range(0, 19) == 0) begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NR; i++) words[i] = '0;
      #2;
      // Reset state
      repeat (3) cycle();
      resetn = 1'b1;
      cycle();

      // Round-robin under continuous demand from all four requesters
      g_owner.delete(); g_cyc.delete();
      for (int i = 0; i < NR; i++) words[i] = 16'($urandom);
      req_valid = 4'b1111;
      repeat (5 * PER) begin
         cycle();
         for (int i = 0; i < NR; i++) if (accepted[i]) words[i] = 16'($urandom);
      end
      check("rr_grant_count_ge5", 32'(g_owner.size() >= 5), 32'd1);
      if (g_owner.size() >= 5) begin
         for (int k = 0; k < 5; k++) begin
            check("rr_owner", 32'(g_owner[k]), 32'(k % NR));
            check("rr_spacing", 32'(g_cyc[k] - g_cyc[0]), 32'(k * PER));
         end
      end
      req_valid = '0;
      repeat (PER) cycle();

      // Pointer: grant 2, then only 0 and 3 valid -> 3 then 0
      g_owner.delete(); g_cyc.delete();
      req_valid = 4'b0100; words[2] = 16'h1357;
      cycle();
      req_valid = 4'b1001; words[0] = 16'h0F0F; words[3] = 16'hF00D;
      repeat (3 * PER) begin
         cycle();
         req_valid = req_valid & ~accepted;
      end
      check("ptr_grant_count", 32'(g_owner.size()), 32'd3);
      if (g_owner.size() == 3) begin
         check("ptr_first", 32'(g_owner[0]), 32'd2);
         check("ptr_second", 32'(g_owner[1]), 32'd3);
         check("ptr_third", 32'(g_owner[2]), 32'd0);
      end

      // Single word from requester 1, then requester 2 raises valid mid-shift of requester 0
      req_valid = 4'b0010; words[1] = 16'hA5C3;
      cycle();
      req_valid = 4'b0000;
      repeat (PER) cycle();
      req_valid = 4'b0001; words[0] = 16'h8001;
      cycle();
      req_valid = 4'b0000;
      repeat (6) cycle();
      req_valid = 4'b0100; words[2] = 16'h7E7E;
      repeat (2 * PER) begin
         cycle();
         req_valid = req_valid & ~accepted;
      end

      // Reset in the middle of a word
      req_valid = 4'b1000; words[3] = 16'hBEEF;
      cycle();
      req_valid = 4'b0000;
      repeat (7) cycle();
      resetn = 1'b0;
      repeat (2) cycle();
      resetn = 1'b1;
      cycle();
      check("busy_after_reset", 32'(busy), 32'd0);
      repeat (4) cycle();

      // Randomized traffic with occasional resets
      repeat (1500) begin
         drive_random();
         if ($urandom_range(0, 299) == 0) begin
            resetn = 1'b0;
            cycle();
            resetn = 1'b1;
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
